sync_fifo: RTL
==============

// Module: sync_fifo
// PURPOSE
//   Single-clock parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering.
//   Adds non-power-of-2 depth, occupancy count, programmable almost-full/almost-empty flags,
//   sticky overflow/underflow error flags and a synchronous clear.
//   Sits between a same-clock producer and consumer, e.g. ahead of a CDC FIFO.
// PARAMETERS
//   Depth        4  number of entries; integer >= 2, need not be a power of 2
//   Width        8  data word width in bits, >= 1
//   AlmostFull   3  o_almost_full threshold (count >= AlmostFull); 1..Depth
//   AlmostEmpty  1  o_almost_empty threshold (count <= AlmostEmpty); 0..Depth-1
// PORTS
//   clk             in   1                    single clock; all state updates on rising edge
//   rst             in   1                    asynchronous reset, active-high
//   i_clr           in   1                    synchronous clear; empties FIFO, clears error flags
//   i_wr_en         in   1                    write request
//   i_wr_data       in   Width                write data
//   i_rd_en         in   1                    read request (pop)
//   o_rd_data       out  Width                read data (timing depends on SYNC_FIFO_FWFT_EN)
//   o_rd_valid      out  1                    o_rd_data holds a valid popped/head word
//   o_count         out  $clog2(Depth+1)      current occupancy, 0..Depth
//   o_full          out  1                    count == Depth
//   o_empty         out  1                    count == 0
//   o_almost_full   out  1                    count >= AlmostFull
//   o_almost_empty  out  1                    count <= AlmostEmpty
//   o_overflow      out  1                    sticky: write attempted while full
//   o_underflow     out  1                    sticky: read attempted while empty
// BEHAVIOUR
//   - Reset (async assert): pointers=0, count=0, o_empty=1, o_almost_empty=1, o_full=0,
//     o_almost_full=0, o_overflow=0, o_underflow=0, o_rd_valid=0, o_rd_data=0. Memory not reset.
//   - Write accepted iff i_wr_en && !o_full; read accepted iff i_rd_en && !o_empty.
//     Acceptance is evaluated against the registered flags of the current cycle.
//   - Both accepted same cycle: count unchanged, both pointers advance.
//   - i_wr_en while full: write dropped, o_overflow set. i_rd_en while empty: o_underflow set.
//     Simultaneous read while full: read accepted, write still dropped (overflow set).
//   - Pointers wrap Depth-1 -> 0 (explicit compare, not power-of-2 masking).
//   - Count, all four flags registered; they reflect accepted ops one cycle after the edge.
//   - i_clr (sync) has priority over wr/rd that cycle: pointers/count -> 0, flags return to
//     reset values, o_rd_valid -> 0; memory contents untouched.
//   - rst asserted mid-operation: all state returns to reset values immediately; in-flight
//     read data is lost; o_rd_valid drops asynchronously.
// CONFIGURATION
//   SYNC_FIFO_FWFT_EN undefined (standard mode):
//     - o_rd_data registered; updated on the edge an accepted read occurs, valid the next cycle.
//     - o_rd_valid pulses 1 cycle after each accepted read; o_rd_data holds last value otherwise.
//   SYNC_FIFO_FWFT_EN defined (first-word fall-through):
//     - o_rd_data = head entry combinationally; o_rd_valid = !o_empty.
//     - i_rd_en acknowledges/pops the shown word; next word visible the following cycle.
//     - Write to empty FIFO: word visible (o_rd_valid=1) the cycle after the write edge.
// TESTING
//   1 reset -> o_empty=1, o_almost_empty=1, o_count=0, o_full=0, o_rd_valid=0, flags 0.
//   2 Depth=5: write 0x11..0x55 -> o_full=1, o_count=5; read 5 -> 0x11..0x55 in order, o_empty=1.
//   3 Depth=5, 12 interleaved writes/reads crossing the wrap point -> data order preserved.
//   4 full + wr+rd same cycle -> read pops, write dropped, o_overflow=1, o_count=4;
//     empty + rd -> o_underflow=1, o_count stays 0.
//   5 AlmostFull=3, AlmostEmpty=1: counts 0..5 -> almost_empty 1,1,0,0,0,0; almost_full 0,0,0,1,1,1.
//   6 count=3 + i_clr with i_wr_en=1 -> next cycle o_count=0, o_empty=1, errors cleared;
//     repeat 2 with SYNC_FIFO_FWFT_EN defined -> 0x11 visible 1 cycle after first write, no pop.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with arbitrary (non power-of-2) depth,
//                occupancy count, programmable almost-full/almost-empty
//                thresholds, sticky overflow/underflow flags and a
//                synchronous clear.
//                Define SYNC_FIFO_FWFT_EN for first-word fall-through reads;
//                leave it undefined for registered (one-cycle latency) reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned ALMOST_FULL  = 3,
   parameter int unsigned ALMOST_EMPTY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clr,
   input  logic                       i_wr_en,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_rd_en,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_rd_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_almost_full,
   output logic                       o_almost_empty,
   output logic                       o_overflow,
   output logic                       o_underflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          afull_q, afull_d;
   logic          aempty_q, aempty_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          wr_acc, rd_acc;

   // Acceptance is judged against the registered flags only.
   assign wr_acc = i_wr_en && !full_q;
   assign rd_acc = i_rd_en && !empty_q;

   // Next-state for pointers, occupancy, flags and sticky errors.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (i_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
         if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (i_wr_en && full_q)  ovf_d = 1'b1;
         if (i_rd_en && empty_q) udf_d = 1'b1;
      end
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CW'(ALMOST_FULL));
      aempty_d = (count_d <= CW'(ALMOST_EMPTY));
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage array; deliberately not reset, and a clear does not write it.
   always_ff @(posedge clk) begin
      if (wr_acc && !i_clr) mem_q[wr_ptr_q] <= i_wr_data;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head entry shown directly; masked to zero while empty so reset reads 0.
   assign o_rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign o_rd_valid = !empty_q;
`else
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;

   // Registered read port: data captured on the accepted-read edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc && !i_clr;
         if (rd_acc && !i_clr) rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   assign o_rd_data  = rd_data_q;
   assign o_rd_valid = rd_valid_q;
`endif

   assign o_count        = count_q;
   assign o_full         = full_q;
   assign o_empty        = empty_q;
   assign o_almost_full  = afull_q;
   assign o_almost_empty = aempty_q;
   assign o_overflow     = ovf_q;
   assign o_underflow    = udf_q;

endmodule
`default_nettype wire
